ysyx_23060201_wbu: RTL and testbench

YSYX_23060201_WBU -- requirements
Module: ysyx_23060201_WBU

---
 rtl/ysyx_23060201_wbu.sv | 95 +++++++++
 tb/tb_ysyx_23060201_wbu.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060201_wbu.sv
// ysyx_23060201_wbu: write-back unit with a 2-entry result FIFO, a registered GPR write port and a per-register pending scoreboard
// clk, rst_n             : clock, synchronous active-low reset
// in_*                   : EXU/LSU result handshake {rd, rd_wen, wdata}; in_ready = FIFO not full
// wb_hold                : freezes draining of the FIFO
// iss_*                  : decode issue handshake; iss_ready drops when pnd[iss_rd] would overflow
// chk_rs1/chk_rs2        : sources checked against the scoreboard, chk_busy[1:0] = pending flags
// gpr_wen/waddr/wdata    : registered register-file write port
// commit_cnt             : number of retired results
module ysyx_23060201_wbu #(
    parameter int GPR_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [GPR_ADDR_WIDTH-1:0] in_rd,
    input  logic                      in_rd_wen,
    input  logic [DATA_WIDTH-1:0]     in_wdata,
    input  logic                      wb_hold,
    input  logic                      iss_valid,
    output logic                      iss_ready,
    input  logic [GPR_ADDR_WIDTH-1:0] iss_rd,
    input  logic                      iss_rd_wen,
    input  logic [GPR_ADDR_WIDTH-1:0] chk_rs1,
    input  logic [GPR_ADDR_WIDTH-1:0] chk_rs2,
    output logic [1:0]                chk_busy,
    output logic                      gpr_wen,
    output logic [GPR_ADDR_WIDTH-1:0] gpr_waddr,
    output logic [DATA_WIDTH-1:0]     gpr_wdata,
    output logic [31:0]               commit_cnt
);
    localparam int NREG = 1 << GPR_ADDR_WIDTH;
    logic [GPR_ADDR_WIDTH-1:0] rd_q [2];
    logic                      wen_q [2];
    logic [DATA_WIDTH-1:0]     data_q [2];
    logic                      wp, rp;
    logic [1:0]                cnt;
    logic [1:0]                pnd [NREG];
    logic [NREG-1:0]           inc, dec;
    logic                      push, pop, underflow;
    logic [GPR_ADDR_WIDTH-1:0] head_rd;
    logic                      head_wen;
    assign head_rd   = rd_q[rp];
    assign head_wen  = wen_q[rp];
    assign in_ready  = cnt != 2'd2;
    assign push      = in_valid && in_ready;
    assign pop       = cnt != 2'd0 && !wb_hold;
    assign iss_ready = !(iss_rd_wen && iss_rd != '0 && pnd[iss_rd] == 2'd3);
    // one-hot increment/decrement requests; bit 0 masked so x0 is never tracked
    assign inc = (iss_valid && iss_ready && iss_rd_wen) ? (NREG'(1) << iss_rd) & ~NREG'(1) : '0;
    assign dec = (pop && head_wen) ? (NREG'(1) << head_rd) & ~NREG'(1) : '0;
    assign underflow = pop && head_wen && head_rd != '0 && pnd[head_rd] == 2'd0;
    assign chk_busy  = {chk_rs2 != '0 && pnd[chk_rs2] != 2'd0, chk_rs1 != '0 && pnd[chk_rs1] != 2'd0};
    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[wp]   <= in_rd;
            wen_q[wp]  <= in_rd_wen;
            data_q[wp] <= in_wdata;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp         <= 1'b0;
            rp         <= 1'b0;
            cnt        <= 2'd0;
            gpr_wen    <= 1'b0;
            gpr_waddr  <= '0;
            gpr_wdata  <= '0;
            commit_cnt <= 32'd0;
        end else begin
            wp         <= wp ^ push;
            rp         <= rp ^ pop;
            cnt        <= cnt + 2'(push) - 2'(pop);
            gpr_wen    <= pop && head_wen && head_rd != '0;
            commit_cnt <= commit_cnt + 32'(pop);
            if (pop) begin
                gpr_waddr <= head_rd;
                gpr_wdata <= data_q[rp];
            end
        end
    end
    // simultaneous inc/dec cancels; a decrement of a zero counter saturates at 0
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (!rst_n)
                pnd[i] <= 2'd0;
            else if (inc[i] && !dec[i])
                pnd[i] <= pnd[i] + 2'd1;
            else if (dec[i] && !inc[i] && pnd[i] != 2'd0)
                pnd[i] <= pnd[i] - 2'd1;
        end
    end
    no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !underflow);
endmodule

// File: tb/tb_ysyx_23060201_wbu.sv
// tb_ysyx_23060201_wbu: directed self-checking bench for the write-back unit
module tb_ysyx_23060201_wbu;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, in_rd_wen, wb_hold;
    logic        iss_valid, iss_ready, iss_rd_wen, gpr_wen;
    logic [4:0]  in_rd, iss_rd, chk_rs1, chk_rs2, gpr_waddr;
    logic [31:0] in_wdata, gpr_wdata, commit_cnt;
    logic [1:0]  chk_busy;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ysyx_23060201_wbu dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_rd_wen(in_rd_wen), .in_wdata(in_wdata), .wb_hold(wb_hold),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rd(iss_rd), .iss_rd_wen(iss_rd_wen),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_busy(chk_busy),
        .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata), .commit_cnt(commit_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd);
        iss_valid = 1'b1; iss_rd = rd; iss_rd_wen = 1'b1;
        step();
        iss_valid = 1'b0;
    endtask

    task automatic put(input logic [4:0] rd, input logic [31:0] d);
        in_valid = 1'b1; in_rd = rd; in_rd_wen = 1'b1; in_wdata = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 0; in_rd = 0; in_rd_wen = 0; in_wdata = 0; wb_hold = 0;
        iss_valid = 0; iss_rd = 0; iss_rd_wen = 0; chk_rs1 = 0; chk_rs2 = 0;
        step(); step();
        rst_n = 1'b1;
        step();
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        tests++; if (iss_ready !== 1'b1) begin fails++; $display("FAIL reset_iss_ready got %b want 1", iss_ready); end
        tests++; if (chk_busy !== 2'b00) begin fails++; $display("FAIL reset_busy got %b want 00", chk_busy); end
        tests++; if ({gpr_wen, gpr_waddr, gpr_wdata} !== 38'd0) begin fails++; $display("FAIL reset_gpr got %b/%0d/%h want 0/0/0", gpr_wen, gpr_waddr, gpr_wdata); end
        tests++; if (commit_cnt !== 32'd0) begin fails++; $display("FAIL reset_commit got %0d want 0", commit_cnt); end
    endtask

    task automatic test_single_write();
        chk_rs1 = 5'd5;
        iss_valid = 1'b1; iss_rd = 5'd5; iss_rd_wen = 1'b1;
        #1;
        tests++; if (chk_busy[0] !== 1'b0) begin fails++; $display("FAIL issue_not_early got %b want 0", chk_busy[0]); end
        step();
        iss_valid = 1'b0;
        tests++; if (chk_busy[0] !== 1'b1) begin fails++; $display("FAIL issue_busy got %b want 1", chk_busy[0]); end
        put(5'd5, 32'hDEADBEEF);
        step();
        in_valid = 1'b0;
        tests++; if (gpr_wen !== 1'b0) begin fails++; $display("FAIL single_early got %b want 0", gpr_wen); end
        step();
        tests++; if ({gpr_wen, gpr_waddr, gpr_wdata} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin fails++; $display("FAIL single_write got %b/%0d/%h want 1/5/deadbeef", gpr_wen, gpr_waddr, gpr_wdata); end
        tests++; if (commit_cnt !== 32'd1) begin fails++; $display("FAIL single_commit got %0d want 1", commit_cnt); end
        tests++; if (chk_busy[0] !== 1'b0) begin fails++; $display("FAIL single_busy_clear got %b want 0", chk_busy[0]); end
        step();
        tests++; if ({gpr_wen, gpr_waddr, gpr_wdata} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin fails++; $display("FAIL single_pulse_end got %b/%0d/%h want 0/5/deadbeef", gpr_wen, gpr_waddr, gpr_wdata); end
    endtask

    task automatic test_x0_write();
        put(5'd0, 32'h1234);
        step();
        in_valid = 1'b0;
        step();
        tests++; if (gpr_wen !== 1'b0) begin fails++; $display("FAIL x0_wen got %b want 0", gpr_wen); end
        tests++; if (commit_cnt !== 32'd2) begin fails++; $display("FAIL x0_commit got %0d want 2", commit_cnt); end
        chk_rs1 = 5'd0; chk_rs2 = 5'd5;
        #1;
        tests++; if (chk_busy !== 2'b00) begin fails++; $display("FAIL x0_busy got %b want 00", chk_busy); end
    endtask

    task automatic test_back_pressure();
        issue(5'd1); issue(5'd2); issue(5'd3);
        wb_hold = 1'b1;
        put(5'd1, 32'h11);
        step();
        put(5'd2, 32'h22);
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready1 got %b want 1", in_ready); end
        step();
        put(5'd3, 32'h33);
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_full got %b want 0", in_ready); end
        step(); step();
        tests++; if ({in_ready, gpr_wen} !== 2'b00) begin fails++; $display("FAIL bp_held got %b want 00", {in_ready, gpr_wen}); end
        wb_hold = 1'b0;
        step();
        tests++; if ({gpr_wen, gpr_waddr, gpr_wdata} !== {1'b1, 5'd1, 32'h11}) begin fails++; $display("FAIL bp_w1 got %b/%0d/%h want 1/1/11", gpr_wen, gpr_waddr, gpr_wdata); end
        step();
        in_valid = 1'b0;
        tests++; if ({gpr_wen, gpr_waddr, gpr_wdata} !== {1'b1, 5'd2, 32'h22}) begin fails++; $display("FAIL bp_w2 got %b/%0d/%h want 1/2/22", gpr_wen, gpr_waddr, gpr_wdata); end
        step();
        tests++; if ({gpr_wen, gpr_waddr, gpr_wdata} !== {1'b1, 5'd3, 32'h33}) begin fails++; $display("FAIL bp_w3 got %b/%0d/%h want 1/3/33", gpr_wen, gpr_waddr, gpr_wdata); end
        step();
        tests++; if (gpr_wen !== 1'b0) begin fails++; $display("FAIL bp_no_dup got %b want 0", gpr_wen); end
        tests++; if (commit_cnt !== 32'd5) begin fails++; $display("FAIL bp_commit got %0d want 5", commit_cnt); end
    endtask

    task automatic test_scoreboard();
        issue(5'd7); issue(5'd7); issue(5'd7);
        chk_rs1 = 5'd7; chk_rs2 = 5'd7;
        iss_valid = 1'b1; iss_rd = 5'd7; iss_rd_wen = 1'b1;
        #1;
        tests++; if (iss_ready !== 1'b0) begin fails++; $display("FAIL sb_full_stall got %b want 0", iss_ready); end
        tests++; if (chk_busy !== 2'b11) begin fails++; $display("FAIL sb_busy got %b want 11", chk_busy); end
        iss_rd_wen = 1'b0;
        #1;
        tests++; if (iss_ready !== 1'b1) begin fails++; $display("FAIL sb_nowen_ready got %b want 1", iss_ready); end
        iss_valid = 1'b0;
        put(5'd7, 32'h70); step();
        put(5'd7, 32'h71); step();
        put(5'd7, 32'h72); step();
        in_valid = 1'b0;
        tests++; if (chk_busy !== 2'b11) begin fails++; $display("FAIL sb_busy_last got %b want 11", chk_busy); end
        step();
        tests++; if (chk_busy !== 2'b00) begin fails++; $display("FAIL sb_clear got %b want 00", chk_busy); end
        tests++; if (commit_cnt !== 32'd8) begin fails++; $display("FAIL sb_commit got %0d want 8", commit_cnt); end
    endtask

    task automatic test_same_cycle();
        chk_rs1 = 5'd9; chk_rs2 = 5'd0;
        issue(5'd9);
        put(5'd9, 32'h90); step();
        in_valid = 1'b0;
        iss_valid = 1'b1; iss_rd = 5'd9; iss_rd_wen = 1'b1;
        #1;
        tests++; if (iss_ready !== 1'b1) begin fails++; $display("FAIL same_ready got %b want 1", iss_ready); end
        step();
        iss_valid = 1'b0;
        tests++; if (chk_busy !== 2'b01) begin fails++; $display("FAIL same_busy got %b want 01", chk_busy); end
        put(5'd9, 32'h91); step();
        in_valid = 1'b0;
        step();
        tests++; if (chk_busy !== 2'b00) begin fails++; $display("FAIL same_count_one got %b want 00", chk_busy); end
        tests++; if (commit_cnt !== 32'd10) begin fails++; $display("FAIL same_commit got %0d want 10", commit_cnt); end
    endtask

    task automatic test_mid_reset();
        chk_rs1 = 5'd4;
        issue(5'd4); issue(5'd4);
        wb_hold = 1'b1;
        put(5'd4, 32'h40); step();
        put(5'd4, 32'h41); step();
        in_valid = 1'b0;
        tests++; if ({in_ready, chk_busy[0]} !== 2'b01) begin fails++; $display("FAIL mr_pre got %b want 01", {in_ready, chk_busy[0]}); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; wb_hold = 1'b0;
        tests++; if ({gpr_wen, in_ready, chk_busy} !== 4'b0100) begin fails++; $display("FAIL mr_state got %b want 0100", {gpr_wen, in_ready, chk_busy}); end
        tests++; if (commit_cnt !== 32'd0) begin fails++; $display("FAIL mr_commit got %0d want 0", commit_cnt); end
        step(); step();
        tests++; if ({gpr_wen, commit_cnt} !== 33'd0) begin fails++; $display("FAIL mr_no_drain got %b/%0d want 0/0", gpr_wen, commit_cnt); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_x0_write();
        test_back_pressure();
        test_scoreboard();
        test_same_cycle();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
